sp_sram_stream_fifo: RTL and testbench
======================================

Name: sp_sram_stream_fifo

Overview:
- Streaming FIFO controller that drives one 128x32 single-port SRAM macro wrapper through its CE/WE/A/D/Q pins.
- Presents a valid/ready push interface upstream and a valid/ready pop interface downstream.
- Arbitrates the single RAM port between writes and reads each cycle.
- Hides the RAM's one-cycle read latency behind a 2-entry output prefetch buffer, so the consumer sees registered, back-to-back data.

Parameters:
- WIDTH, 32, data width; must match the RAM word width.
- DEPTH, 128, RAM entries; must be a power of two.
- ADDR_WIDTH, 7, log2(DEPTH).
- CNT_WIDTH, 8, width of level_o; must hold DEPTH+2.

Ports:
- clk  in  1  single clock; also the RAM wrapper clock.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous flush; same effect as rst on FIFO state.
- in_valid  in  1  push request.
- in_ready  out  1  push accepted when in_valid && in_ready.
- in_data  in  WIDTH  push data.
- out_valid  out  1  pop data available.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  WIDTH  pop data, driven straight from a register.
- ram_ce  out  1  RAM chip enable, active-high.
- ram_we  out  1  RAM write enable, active-high.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_d  out  WIDTH  RAM write data.
- ram_q  in  WIDTH  RAM read data; valid the cycle after a read (ce=1, we=0).
- level_o  out  CNT_WIDTH  total entries held = ram_cnt + rd_inflight + obuf_cnt.
- empty_o  out  1  level_o==0.
- full_o  out  1  ram_cnt==DEPTH.

Behaviour:
- Reset/clr (synchronous, either high at a clock edge):
  - wptr, rptr, ram_cnt, obuf_cnt, rd_inflight and last_wr all go to 0.
  - Outputs read: in_ready=0 during rst/clr, out_valid=0, level_o=0, empty_o=1, full_o=0, ram_ce=0.
  - Data in the RAM and obuf is discarded. A read in flight is dropped; the following cycle's ram_q is ignored.
  - rst takes priority over clr, with identical effect.
- Internal state:
  - wptr, rptr: ADDR_WIDTH bits, wrap DEPTH-1 -> 0.
  - ram_cnt: 0..DEPTH.
  - rd_inflight: 1 bit.
  - obuf: 2-entry register FIFO with obuf_cnt 0..2.
  - last_wr: 1 bit, set to the value of wr_fire each cycle.
- Arbitration, evaluated every cycle:
  - rd_want = ram_cnt!=0 && (obuf_cnt + rd_inflight) < 2, where obuf_cnt is computed after this cycle's pop is applied.
  - rd_grant = rd_want && (obuf_cnt==0 || last_wr || !in_valid_q), where in_valid_q is in_valid registered.
  - This keeps rd_grant independent of the current in_valid. Reads therefore win whenever the output would starve, and otherwise alternate with writes.
  - in_ready = !rst && !clr && ram_cnt<DEPTH && !rd_grant. No combinational path from in_valid to in_ready.
  - wr_fire = in_valid && in_ready.
- RAM drive:
  - ram_ce = wr_fire | rd_grant; ram_we = wr_fire.
  - ram_addr = wr_fire ? wptr : rptr.
  - ram_d = in_data.
  - wr_fire and rd_grant are never high in the same cycle.
- Counters:
  - wr_fire: wptr++ and ram_cnt++.
  - rd_grant: rptr++, ram_cnt--, rd_inflight<=1.
  - Otherwise rd_inflight<=0.
- Capture:
  - When rd_inflight==1, ram_q is written into obuf at the tail.
  - Capture and pop in the same cycle are allowed; obuf_cnt stays the same.
  - Capture never overflows, because of the rd_want bound.
- Output:
  - out_valid = obuf_cnt!=0; out_data = obuf head.
  - Pop when out_valid && out_ready. obuf shifts so the next entry is visible the next cycle.
- Latency:
  - Push accepted at cycle t into an idle, empty FIFO: read granted t+1, ram_q valid t+2, out_valid=1 at t+3.
  - Sustained throughput: 1 word per 2 cycles when both sides are active (single port). 1 word/cycle for pure fill or pure drain.
- Boundaries:
  - full_o (ram_cnt==DEPTH): in_ready=0. Total capacity is DEPTH+2 with obuf full.
  - Empty: no RAM access; ram_ce=0.
  - Pointer wrap is seamless.
  - out_data stays stable while out_valid && !out_ready.
  - in_data is ignored when in_ready=0.

Test Plan:
- Single word: reset, push 0xA5A5_0001 at cycle 5 -> ram_ce=1/ram_we=1/addr=0 at cycle 5; read at addr 0 at cycle 6; out_valid=1 with out_data=0xA5A5_0001 at cycle 8; level_o 1 throughout, 0 after pop.
- Fill to full with out_ready=0: push 0..129 -> after 130 accepts obuf holds 0,1 and ram_cnt=128; full_o=1, in_ready=0, level_o=130; push 130 stalls until one pop.
- Drain order and wrap: fill 128 words, drain all, then push/pop 300 incrementing words at random ready -> exact incrementing order; pointers wrap twice with no loss or duplication.
- Concurrent streaming with in_valid=1 and out_ready=1 continuous -> one pop every 2 cycles steady-state; no cycle with ram_ce=1 and both read and write intent; out_valid never drops once primed.
- Backpressure: out_ready toggling 1-0-1 -> out_data held constant while stalled; obuf_cnt never exceeds 2; no capture lost.
- Flush mid-op: 10 words queued with a read in flight, assert clr for one cycle -> next cycle level_o=0, out_valid=0, empty_o=1; stale ram_q not captured; a new push of 0x0000_00FF is output first, at addr 0.

Source files
------------

// File: rtl/sp_sram_stream_fifo.sv
// sp_sram_stream_fifo
// Valid/ready streaming FIFO built on one single-port SRAM macro. Writes and
// reads share the RAM port; a 2-entry register buffer on the output hides the
// RAM's one-cycle read latency so the consumer always sees registered data.
module sp_sram_stream_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 128,
    parameter int ADDR_WIDTH = 7,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    // push side
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    // pop side
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    // SRAM macro pins
    output logic                  ram_ce,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WIDTH-1:0]      ram_d,
    input  logic [WIDTH-1:0]      ram_q,
    // status
    output logic [CNT_WIDTH-1:0]  level_o,
    output logic                  empty_o,
    output logic                  full_o
);

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

    // RAM-side bookkeeping
    logic [ADDR_WIDTH-1:0] wptr_q, rptr_q;
    logic [ADDR_WIDTH:0]   ram_cnt_q;
    logic                  rd_inflight_q;
    logic                  last_wr_q;
    logic                  in_valid_q;

    // output prefetch buffer; entry 0 is the head
    logic [WIDTH-1:0]      obuf_q [2];
    logic [WIDTH-1:0]      obuf_d [2];
    logic [1:0]            obuf_cnt_q, obuf_cnt_d;

    logic                  flush;
    logic                  pop;
    logic [1:0]            obuf_left;
    logic [2:0]            pending;
    logic                  ram_full;
    logic                  rd_want;
    logic                  rd_grant;
    logic                  wr_fire;

    // Port arbitration: decide this cycle's single RAM access.
    always_comb begin
        flush     = rst | clr;
        pop       = (obuf_cnt_q != 2'd0) && out_ready;
        obuf_left = obuf_cnt_q - {1'b0, pop};
        pending   = {1'b0, obuf_left} + {2'b0, rd_inflight_q};
        ram_full  = (ram_cnt_q == DEPTH_CNT);
        rd_want   = (ram_cnt_q != '0) && (pending < 3'd2);
        // Reads win when the output would starve, after a write, when the
        // producer was idle last cycle, or when a write is impossible anyway
        // (RAM full) so a draining consumer can never lock up the port.
        rd_grant  = !flush && rd_want &&
                    (obuf_left == 2'd0 || last_wr_q || !in_valid_q || ram_full);
        in_ready  = !flush && !ram_full && !rd_grant;
        wr_fire   = in_valid && in_ready;
    end

    // SRAM pin drive and status outputs.
    always_comb begin
        ram_ce    = wr_fire | rd_grant;
        ram_we    = wr_fire;
        ram_addr  = wr_fire ? wptr_q : rptr_q;
        ram_d     = in_data;
        out_valid = (obuf_cnt_q != 2'd0);
        out_data  = obuf_q[0];
        level_o   = CNT_WIDTH'(ram_cnt_q) + CNT_WIDTH'(rd_inflight_q) + CNT_WIDTH'(obuf_cnt_q);
        empty_o   = (level_o == '0);
        full_o    = ram_full;
    end

    // Prefetch buffer next state: shift on pop, then capture returning RAM data at the tail.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        obuf_d     = obuf_q;
        obuf_cnt_d = obuf_left + {1'b0, rd_inflight_q};
        if (pop) begin
            obuf_d[0] = obuf_q[1];
        end
        // capture index is 0 or 1; the rd_want bound keeps it below 2
        if (rd_inflight_q) begin
            obuf_d[obuf_left[0]] = ram_q;
        end
    end

    // Control state: pointers, counters and arbitration history; flushed by rst or clr.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (flush) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            ram_cnt_q     <= '0;
            rd_inflight_q <= 1'b0;
            last_wr_q     <= 1'b0;
            in_valid_q    <= 1'b0;
            obuf_cnt_q    <= 2'd0;
        end else begin
            if (wr_fire) begin
                wptr_q <= wptr_q + ADDR_WIDTH'(1);
            end
            if (rd_grant) begin
                rptr_q <= rptr_q + ADDR_WIDTH'(1);
            end
            case ({wr_fire, rd_grant})
                2'b10:   ram_cnt_q <= ram_cnt_q + 1'b1;
                2'b01:   ram_cnt_q <= ram_cnt_q - 1'b1;
                default: ram_cnt_q <= ram_cnt_q;
            endcase
            // dropping rd_inflight on flush is what discards the stale ram_q
            rd_inflight_q <= rd_grant;
            last_wr_q     <= wr_fire;
            in_valid_q    <= in_valid;
            obuf_cnt_q    <= obuf_cnt_d;
        end
    end

    // Prefetch buffer data registers.
    always_ff @(posedge clk) begin
        // NOTE: data storage is not reset; obuf_cnt_q alone decides which entries are meaningful.
        obuf_q <= obuf_d;
    end

endmodule

// File: tb/tb_sp_sram_stream_fifo.sv
// tb_sp_sram_stream_fifo
// Random and directed stimulus against a queue-based FIFO model plus a
// behavioural single-port RAM with one-cycle read latency.
module tb_sp_sram_stream_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 128;
    localparam int AW    = 7;
    localparam int CW    = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             ram_ce;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_d;
    logic [WIDTH-1:0] ram_q = '0;
    logic [CW-1:0]    level_o;
    logic             empty_o;
    logic             full_o;

    always #5 clk = ~clk;

    sp_sram_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d), .ram_q(ram_q),
        .level_o(level_o), .empty_o(empty_o), .full_o(full_o)
    );

    // behavioural single-port SRAM: write or registered read
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) mem[ram_addr] <= ram_d;
            else        ram_q <= mem[ram_addr];
        end
    end

    // reference model and counters
    logic [WIDTH-1:0] exp_q [$];
    int               wr_ptr_m = 0;
    int               rd_ptr_m = 0;
    logic [WIDTH-1:0] next_val = '0;
    int               n_acc  = 0;
    int               n_pops = 0;
    int               total  = 0;
    int               bad    = 0;
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;

    // last sampled DUT outputs
    logic             s_in_ready, s_out_valid, s_ram_ce, s_ram_we, s_full, s_empty;
    logic [WIDTH-1:0] s_out_data;
    logic [AW-1:0]    s_ram_addr;
    logic [CW-1:0]    s_level;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // one clock cycle: drive inputs after the falling edge, sample, check, update model
    task automatic step(input logic r, input logic c, input logic iv, input logic ordy);
        logic fl, fire, popping, rd_issue;
        logic [WIDTH-1:0] head;
        @(negedge clk);
        rst = r; clr = c; in_valid = iv; in_data = next_val; out_ready = ordy;
        #1;
        s_in_ready = in_ready;  s_out_valid = out_valid; s_out_data = out_data;
        s_ram_ce   = ram_ce;    s_ram_we    = ram_we;    s_ram_addr = ram_addr;
        s_level    = level_o;   s_full      = full_o;    s_empty    = empty_o;
        fl       = r | c;
        fire     = iv && in_ready;
        popping  = out_valid && ordy && !fl;
        rd_issue = ram_ce && !ram_we;

        if (fl) begin
            check("flush_in_ready", in_ready, 0);
            check("flush_ram_ce", ram_ce, 0);
        end else begin
            check("level", level_o, exp_q.size());
            check("empty", empty_o, exp_q.size() == 0);
            check("we_is_push", ram_we, fire);
            check("level_cap", exp_q.size() <= DEPTH + 2, 1);
            if (full_o) check("full_blocks_push", in_ready, 0);
            if (exp_q.size() < DEPTH) check("full_early", full_o, 0);
            if (exp_q.size() == 0 && !fire) check("idle_ram", ram_ce, 0);
            if (out_valid) check("valid_nonempty", exp_q.size() > 0, 1);
            if (fire) begin
                check("wr_ce", ram_ce, 1);
                check("wr_addr", ram_addr, wr_ptr_m % DEPTH);
                check("wr_d", ram_d, next_val);
            end
            if (rd_issue) begin
                check("rd_addr", ram_addr, rd_ptr_m % DEPTH);
                check("rd_has_data", rd_ptr_m < wr_ptr_m, 1);
            end
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
            end
            if (popping) begin
                head = (exp_q.size() > 0) ? exp_q[0] : '0;
                check("pop_data", out_data, head);
            end
        end

        if (fl) begin
            exp_q.delete();
            wr_ptr_m = 0;
            rd_ptr_m = 0;
            prev_stall = 1'b0;
        end else begin
            if (fire) begin
                exp_q.push_back(next_val);
                wr_ptr_m++;
                n_acc++;
                next_val = next_val + 1;
            end
            if (rd_issue) rd_ptr_m++;
            if (popping) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                n_pops++;
            end
            prev_stall = out_valid && !ordy;
            prev_data  = out_data;
        end
    endtask

    initial begin
        int target, pops0, cyc;
        logic seen;

        // reset
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("rst_level", s_level, 0);
        check("rst_empty", s_empty, 1);
        check("rst_out_valid", s_out_valid, 0);
        check("rst_full", s_full, 0);
        step(0, 0, 0, 0);

        // single word: latency push -> out_valid is 3 cycles
        next_val = 32'hA5A5_0001;
        step(0, 0, 1, 0);
        check("sw_push_ready", s_in_ready, 1);
        check("sw_push_ce", s_ram_ce, 1);
        check("sw_push_we", s_ram_we, 1);
        check("sw_push_addr", s_ram_addr, 0);
        step(0, 0, 0, 0);
        check("sw_rd_ce", s_ram_ce, 1);
        check("sw_rd_we", s_ram_we, 0);
        check("sw_rd_addr", s_ram_addr, 0);
        check("sw_valid_t1", s_out_valid, 0);
        check("sw_level_t1", s_level, 1);
        step(0, 0, 0, 0);
        check("sw_valid_t2", s_out_valid, 0);
        check("sw_level_t2", s_level, 1);
        step(0, 0, 0, 1);
        check("sw_valid_t3", s_out_valid, 1);
        check("sw_data", s_out_data, 32'hA5A5_0001);
        step(0, 0, 0, 0);
        check("sw_level_after", s_level, 0);
        check("sw_valid_after", s_out_valid, 0);

        // fill to full with consumer stalled
        step(0, 1, 0, 0);
        next_val = '0;
        target = n_acc + DEPTH + 2;
        cyc = 0;
        while (n_acc < target && cyc < 1000) begin
            step(0, 0, 1, 0);
            cyc++;
        end
        check("fill_timeout", n_acc >= target, 1);
        step(0, 0, 1, 0);
        check("fill_full", s_full, 1);
        check("fill_in_ready", s_in_ready, 0);
        check("fill_level", s_level, DEPTH + 2);
        check("fill_head", s_out_data, 0);
        step(0, 0, 1, 1);
        check("fill_pop0", s_out_data, 0);
        target = n_acc + 1;
        cyc = 0;
        while (n_acc < target && cyc < 20) begin
            step(0, 0, 1, 0);
            cyc++;
        end
        check("fill_refill_timeout", n_acc >= target, 1);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 2000) begin
            step(0, 0, 0, ($urandom % 4) != 0);
            cyc++;
        end
        check("drain_timeout", exp_q.size(), 0);

        // random push/pop of 300 incrementing words; pointers wrap twice
        target = n_acc + 300;
        cyc = 0;
        while ((n_acc < target || exp_q.size() > 0) && cyc < 5000) begin
            step(0, 0, (n_acc < target) && (($urandom % 4) != 0), ($urandom % 3) != 0);
            cyc++;
        end
        check("rand_timeout", (n_acc >= target) && (exp_q.size() == 0), 1);

        // continuous streaming: port shared, so about one word every two cycles
        for (int i = 0; i < 50; i++) step(0, 0, 1, 1);
        pops0 = n_pops;
        for (int i = 0; i < 200; i++) step(0, 0, 1, 1);
        check("stream_rate", (n_pops - pops0 >= 97) && (n_pops - pops0 <= 103), 1);

        // flush with a read in flight
        step(0, 1, 0, 0);
        target = n_acc + 10;
        cyc = 0;
        while (n_acc < target && cyc < 100) begin
            step(0, 0, 1, 0);
            cyc++;
        end
        check("fl_fill_timeout", n_acc >= target, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        check("fl_read_issued", s_ram_ce && !s_ram_we, 1);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        check("fl_level", s_level, 0);
        check("fl_out_valid", s_out_valid, 0);
        check("fl_empty", s_empty, 1);
        step(0, 0, 0, 0);
        check("fl_no_stale", s_out_valid, 0);
        next_val = 32'h0000_00FF;
        step(0, 0, 1, 0);
        check("fl_push_ready", s_in_ready, 1);
        check("fl_push_addr", s_ram_addr, 0);
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 8) begin
            step(0, 0, 0, 1);
            if (s_out_valid) begin
                seen = 1'b1;
                check("fl_first_out", s_out_data, 32'h0000_00FF);
            end
            cyc++;
        end
        check("fl_out_timeout", seen, 1);
        step(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
